// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the serial adder sequencer:
//   - SLICE_W    : width of the time-multiplexed slice adder (2 bits)
//   - state_t    : FSM encoding (ST_IDLE=0, ST_RUN=1, ST_DONE=2)
//   - idx_width(): width of the slice index counter, $clog2(nslice) but never 0
package serial_add_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/add_slice2.sv
// add_slice2
//   Combinational 2-bit adder slice with carry in.
//   Ports:
//     a, b   in  [1:0]  slice addends
//     cin    in         carry into bit 0
//     s      out [1:0]  slice sum
//     c_mid  out        carry out of bit 0 (= carry into bit 1)
//     c_out  out        carry out of bit 1
module add_slice2
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               c_mid,
  output logic               c_out
);

  always_comb begin
    s[0]  = a[0] ^ b[0] ^ cin;
    c_mid = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    s[1]  = a[1] ^ b[1] ^ c_mid;
    c_out = (a[1] & b[1]) | (c_mid & (a[1] ^ b[1]));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   WIDTH-bit unsigned adder built from one 2-bit slice adder that is reused
//   over WIDTH/2 cycles, least-significant slice first.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     op_valid/op_ready   operand request handshake (op_a, op_b)
//     res_valid/res_ready result handshake (sum, cout [, ovf])
//     busy                high while an operation is in RUN or DONE
//     ovf                 two's-complement overflow; present only when the
//                         macro SERIAL_ADD_OVF_EN is defined
//   Handshake rule (both ports): a transfer happens on a rising edge where
//   valid and ready are both high. op_ready is high only in IDLE, res_valid
//   only in DONE; the result stays stable until it is taken, and operands
//   offered outside IDLE are neither taken nor remembered.
//   The FSM state is available as the internal signal 'state' for checkers.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [IDX_W:0]     base;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               c_mid;
  logic               c_out;
  logic               accept;
  logic               last;

  // Bit offset of the current slice is idx*2.
  assign base   = {idx, 1'b0};
  assign a_sl   = a_q[base +: SLICE_W];
  assign b_sl   = b_q[base +: SLICE_W];
  assign accept = (state == ST_IDLE) && op_valid;
  assign last   = (idx == IDX_LAST);

  add_slice2 u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry),
    .s     (s_sl),
    .c_mid (c_mid),
    .c_out (c_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (op_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (res_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: op_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        res_valid = 1'b1;
        busy      = 1'b1;
      end
      default: op_ready = 1'b0;
    endcase
  end

  // Datapath: operands are captured only on accept; sum is filled one slice
  // per RUN cycle, untouched slices keep whatever they held before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_q   <= op_a;
      b_q   <= op_b;
      idx   <= '0;
      carry <= 1'b0;
    end else if (state == ST_RUN) begin
      sum[base +: SLICE_W] <= s_sl;
      carry                <= c_out;
      if (last) cout <= c_out;
      else      idx  <= idx + 1'b1;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // In the last slice c_mid is the carry into the MSB and c_out the carry out
  // of it; their difference flags signed overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf <= 1'b0;
    else if (accept)                ovf <= 1'b0;
    else if (state == ST_RUN && last) ovf <= c_mid ^ c_out;
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        op_valid8 = 1'b0, res_ready8 = 1'b0;
  logic [7:0]  op_a8 = '0, op_b8 = '0;
  logic        op_ready8, res_valid8, cout8, busy8, ovf8;
  logic [7:0]  sum8;

  logic        op_valid16 = 1'b0, res_ready16 = 1'b0;
  logic [15:0] op_a16 = '0, op_b16 = '0;
  logic        op_ready16, res_valid16, cout16, busy16, ovf16;
  logic [15:0] sum16;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid8), .op_ready(op_ready8), .op_a(op_a8), .op_b(op_b8),
    .res_valid(res_valid8), .res_ready(res_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid16), .op_ready(op_ready16), .op_a(op_a16), .op_b(op_b16),
    .res_valid(res_valid16), .res_ready(res_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf16)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];      // {ovf, cout, sum} for the 8-bit stream
  logic       stream_on = 1'b0;
  int         stream_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer addition, overflow from operand/result signs.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b};
    o = (a[7] == b[7]) && (t[7] != a[7]);
    return {o, t[8], t[7:0]};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t[16], t[15:0]};
  endfunction

  task automatic check_res8(input string name, input logic [9:0] got, input logic [9:0] exp);
    check({name, "/sum"},  32'(got[7:0]), 32'(exp[7:0]));
    check({name, "/cout"}, 32'(got[8]),   32'(exp[8]));
`ifdef SERIAL_ADD_OVF_EN
    check({name, "/ovf"},  32'(got[9]),   32'(exp[9]));
`endif
  endtask

  // Stream monitor: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (stream_on && res_valid8 && res_ready8) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream/unexpected: got sum %0h with empty queue", sum8);
      end else begin
        check_res8("stream", {ovf8, cout8, sum8}, exp_q.pop_front());
      end
      stream_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called with the DUT in IDLE, #1 after a rising edge.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [9:0] got);
    op_a8 = a; op_b8 = b; op_valid8 = 1'b1; res_ready8 = 1'b1;
    @(posedge clk); #1;
    op_valid8 = 1'b0;
    op_a8 = 8'($urandom); op_b8 = 8'($urandom);   // must not disturb the result
    lat = 0;
    while (res_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    got = {ovf8, cout8, sum8};
  endtask

  task automatic op8_checked(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [9:0] exp);
    int lat;
    logic [9:0] got;
    do_op8(a, b, lat, got);
    check({name, "/latency"}, 32'(lat), 32'd4);
    check_res8(name, got, exp);
    @(posedge clk); #1;
    check({name, "/valid_pulse"}, 32'(res_valid8), 32'd0);
  endtask

  task automatic op16_checked(input string name, input logic [15:0] a, input logic [15:0] b);
    int lat;
    logic [17:0] exp;
    exp = model16(a, b);
    op_a16 = a; op_b16 = b; op_valid16 = 1'b1; res_ready16 = 1'b1;
    @(posedge clk); #1;
    op_valid16 = 1'b0;
    op_a16 = 16'($urandom); op_b16 = 16'($urandom);
    lat = 0;
    while (res_valid16 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "/latency"}, 32'(lat), 32'd8);
    check({name, "/sum"},  32'(sum16),  32'(exp[15:0]));
    check({name, "/cout"}, 32'(cout16), 32'(exp[16]));
`ifdef SERIAL_ADD_OVF_EN
    check({name, "/ovf"},  32'(ovf16),  32'(exp[17]));
`endif
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat;
    int n;
    int prev_acc;
    int acc;
    logic [9:0] got;
    logic [7:0] ra, rb;

    tbl[0] = '{8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
    tbl[7] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset/op_ready",  32'(op_ready8),  32'd1);
    check("reset/res_valid", 32'(res_valid8), 32'd0);
    check("reset/busy",      32'(busy8),      32'd0);
    check("reset/sum",       32'(sum8),       32'd0);
    check("reset/cout",      32'(cout8),      32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset/ovf",       32'(ovf8),       32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      op8_checked($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
                  {tbl[i].o, tbl[i].c, tbl[i].s});
    end

    // random single operations against the model
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8_checked($sformatf("rnd%0d", i), ra, rb, model8(ra, rb));
    end

    // backpressure in DONE with a competing request
    op_a8 = 8'h12; op_b8 = 8'h34; op_valid8 = 1'b1; res_ready8 = 1'b0;
    @(posedge clk); #1;
    op_valid8 = 1'b0;
    lat = 0;
    while (res_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("bp/latency", 32'(lat), 32'd4);
    op_a8 = 8'hF0; op_b8 = 8'h0F; op_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp/res_valid", 32'(res_valid8), 32'd1);
      check("bp/op_ready",  32'(op_ready8),  32'd0);
      check("bp/busy",      32'(busy8),      32'd1);
      check_res8("bp/held", {ovf8, cout8, sum8}, model8(8'h12, 8'h34));
      @(posedge clk); #1;
    end
    res_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp/release_op_ready",  32'(op_ready8),  32'd1);
    check("bp/release_res_valid", 32'(res_valid8), 32'd0);
    @(posedge clk); #1;
    check("bp/second_accept", 32'(busy8), 32'd1);
    op_valid8 = 1'b0;
    lat = 0;
    while (res_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("bp/second_latency", 32'(lat), 32'd4);
    check_res8("bp/second", {ovf8, cout8, sum8}, model8(8'hF0, 8'h0F));
    @(posedge clk); #1;

    // reset in the middle of RUN after two slices
    op_a8 = 8'h99; op_b8 = 8'h77; op_valid8 = 1'b1;
    @(posedge clk); #1;
    op_valid8 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("midrst/busy_before",     32'(busy8),     32'd1);
    check("midrst/op_ready_before", 32'(op_ready8), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst/op_ready",  32'(op_ready8),  32'd1);
    check("midrst/res_valid", 32'(res_valid8), 32'd0);
    check("midrst/sum",       32'(sum8),       32'd0);
    check("midrst/busy",      32'(busy8),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8_checked("after_rst", 8'hAA, 8'h55, {1'b0, 1'b0, 8'hFF});

    // back-to-back stream with op_valid held high
    stream_on = 1'b1;
    stream_seen = 0;
    res_ready8 = 1'b1;
    op_valid8 = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op_a8 = ra; op_b8 = rb;
      n = 0;
      while (op_ready8 !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      exp_q.push_back(model8(ra, rb));
      @(posedge clk); #1;
      acc = cyc;
      if (i > 0) check("stream/spacing", 32'(acc - prev_acc), 32'd6);
      prev_acc = acc;
    end
    op_valid8 = 1'b0;
    n = 0;
    while (stream_seen < 10 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check("stream/count", 32'(stream_seen), 32'd10);
    check("stream/drained", 32'(exp_q.size()), 32'd0);
    stream_on = 1'b0;
    @(posedge clk); #1;

    // 16-bit instance
    op16_checked("w16_max", 16'hFFFF, 16'hFFFF);
    check("w16_max/exact_sum", 32'(sum16), 32'h0000FFFE);
    for (int i = 0; i < 4; i++) begin
      op16_checked($sformatf("w16_rnd%0d", i), 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
